// File: rtl/vt_response_capture.sv
// vt_response_capture
//
// Read-side controller for the tester's voltage-translator output path.
// A start request enables the translator in the B->A (DUT->tester) direction,
// waits a settle interval, then takes SAMPLES consecutive synchronized
// samples of the DUT outputs. The translator is then disabled, and the last
// sample is presented on a valid/ready handshake. A sticky flag records
// whether the samples disagreed.
//
// Optional feature (macro VT_CAPTURE_COMPARE_EN):
//   When the macro is defined, the block adds exp_data and mask inputs, both
//   latched on the start edge. It also adds a mismatch output, which flags any
//   masked difference between the captured word and exp_data.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      single-cycle capture request, honoured only in IDLE
//   abort      cancels a capture in SETTLE or SAMPLE
//   busy       high whenever the FSM is not in IDLE
//   dut_out    DUT outputs from the translator A-side (asynchronous)
//   trans_en   translator enable, active high
//   trans_dir  translator direction, 0 = B->A (read)
//   data       captured response word
//   valid      data is available
//   ready      consumer accepts data
//   unstable   samples disagreed during the capture that produced data
//   exp_data   (compare build) expected response word
//   mask       (compare build) bits of exp_data that take part in the compare
//   mismatch   (compare build) masked compare failed

// state  | meaning
// IDLE   | translator off, waiting for start
// SETTLE | translator on, waiting SETTLE_CYCLES for the path to settle
// SAMPLE | translator on, capturing SAMPLES synchronized words
// HOLD   | translator off, data/valid held until ready

module vt_response_capture #(
    parameter int WIDTH         = 16,
    parameter int SETTLE_CYCLES = 8,
    parameter int SAMPLES       = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] dut_out,
    input  logic             ready,
`ifdef VT_CAPTURE_COMPARE_EN
    input  logic [WIDTH-1:0] exp_data,
    input  logic [WIDTH-1:0] mask,
    output logic             mismatch,
`endif
    output logic             busy,
    output logic             trans_en,
    output logic             trans_dir,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             unstable
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_HOLD
    } state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [3:0] SAMPLE_LAST = 4'(SAMPLES - 1);

    state_t           state_q, state_d;
    logic [7:0]       settle_cnt_q, settle_cnt_d;
    logic [3:0]       sample_cnt_q, sample_cnt_d;
    logic [WIDTH-1:0] ref_q, ref_d;
    logic             diff_q, diff_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             unstable_q, unstable_d;
    logic             valid_q, valid_d;
    logic             trans_en_q, trans_en_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic             word_differs;

`ifdef VT_CAPTURE_COMPARE_EN
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic             mismatch_q, mismatch_d;
`endif

    // The first word in SAMPLE becomes the reference, so it never counts as a difference.
    assign word_differs = (sample_cnt_q != 4'd0) && (sync2_q != ref_q);

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        sample_cnt_d = sample_cnt_q;
        ref_d        = ref_q;
        diff_d       = diff_q;
        data_d       = data_q;
        unstable_d   = unstable_q;
        valid_d      = valid_q;
        trans_en_d   = trans_en_q;
`ifdef VT_CAPTURE_COMPARE_EN
        exp_d        = exp_q;
        mask_d       = mask_q;
        mismatch_d   = mismatch_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_SETTLE;
                    settle_cnt_d = 8'd0;
                    trans_en_d   = 1'b1;
`ifdef VT_CAPTURE_COMPARE_EN
                    exp_d        = exp_data;
                    mask_d       = mask;
`endif
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_d    = ST_IDLE;
                    trans_en_d = 1'b0;
                end else if (settle_cnt_q == SETTLE_LAST) begin
                    state_d      = ST_SAMPLE;
                    sample_cnt_d = 4'd0;
                    diff_d       = 1'b0;
                end else begin
                    settle_cnt_d = settle_cnt_q + 8'd1;
                end
            end
            ST_SAMPLE: begin
                if (abort) begin
                    state_d    = ST_IDLE;
                    trans_en_d = 1'b0;
                end else begin
                    if (sample_cnt_q == 4'd0) begin
                        ref_d = sync2_q;
                    end
                    diff_d       = diff_q | word_differs;
                    sample_cnt_d = sample_cnt_q + 4'd1;
                    if (sample_cnt_q == SAMPLE_LAST) begin
                        // The final word is judged here directly because diff_q lags by one edge.
                        state_d    = ST_HOLD;
                        data_d     = sync2_q;
                        unstable_d = diff_q | word_differs;
                        valid_d    = 1'b1;
                        trans_en_d = 1'b0;
`ifdef VT_CAPTURE_COMPARE_EN
                        mismatch_d = |((sync2_q ^ exp_q) & mask_q);
`endif
                    end
                end
            end
            ST_HOLD: begin
                if (ready) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                valid_d    = 1'b0;
                trans_en_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            settle_cnt_q <= '0;
            sample_cnt_q <= '0;
            ref_q        <= '0;
            diff_q       <= 1'b0;
            data_q       <= '0;
            unstable_q   <= 1'b0;
            valid_q      <= 1'b0;
            trans_en_q   <= 1'b0;
            busy_q       <= 1'b0;
            sync1_q      <= '0;
            sync2_q      <= '0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            sample_cnt_q <= sample_cnt_d;
            ref_q        <= ref_d;
            diff_q       <= diff_d;
            data_q       <= data_d;
            unstable_q   <= unstable_d;
            valid_q      <= valid_d;
            trans_en_q   <= trans_en_d;
            busy_q       <= busy_d;
            sync1_q      <= dut_out;
            sync2_q      <= sync1_q;
        end
    end

`ifdef VT_CAPTURE_COMPARE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q      <= '0;
            mask_q     <= '0;
            mismatch_q <= 1'b0;
        end else begin
            exp_q      <= exp_d;
            mask_q     <= mask_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign mismatch = mismatch_q;
`endif

    assign busy      = busy_q;
    assign trans_en  = trans_en_q;
    // This block only ever reads through the translator.
    assign trans_dir = 1'b0;
    assign data      = data_q;
    assign valid     = valid_q;
    assign unstable  = unstable_q;

endmodule

// File: tb/tb_vt_response_capture.sv
// tb_vt_response_capture
//
// Directed bench for vt_response_capture (WIDTH=16, SETTLE_CYCLES=8, SAMPLES=3).
// A table of capture records drives the main path, including glitch
// placement. Hand-written sequences then cover backpressure, abort, the
// asynchronous reset, and the optional compare feature.

module tb_vt_response_capture;

    localparam int W = 16;
    localparam int S = 8;
    localparam int K = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         abort;
    logic [W-1:0] dut_out;
    logic         ready;
    logic [W-1:0] exp_data;
    logic [W-1:0] mask;
    logic         busy;
    logic         trans_en;
    logic         trans_dir;
    logic [W-1:0] data;
    logic         valid;
    logic         unstable;
`ifdef VT_CAPTURE_COMPARE_EN
    logic         mismatch;
`endif

    int total = 0;
    int bad   = 0;

    vt_response_capture #(
        .WIDTH        (W),
        .SETTLE_CYCLES(S),
        .SAMPLES      (K)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .dut_out  (dut_out),
        .ready    (ready),
`ifdef VT_CAPTURE_COMPARE_EN
        .exp_data (exp_data),
        .mask     (mask),
        .mismatch (mismatch),
`endif
        .busy     (busy),
        .trans_en (trans_en),
        .trans_dir(trans_dir),
        .data     (data),
        .valid    (valid),
        .unstable (unstable)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] pattern;
        logic [15:0] glitch_val;
        int          glitch_idx;  // 0 = none, else 1..K sample to corrupt
        logic [15:0] exp_data;
        logic        exp_unstable;
    } cap_vec_t;

    cap_vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a capture and runs to the valid edge. Leaves the DUT in HOLD.
    task automatic capture(input string nm, input logic [15:0] pat, input logic [15:0] gval,
                           input int g, input logic [15:0] exp_d, input logic exp_u);
        int lat;
        int en_cycles;
        bit got;
        dut_out = pat;
        start   = 1'b1;
        tick();
        start    = 1'b0;
        exp_data = ~exp_data;
        mask     = ~mask;
        chk({nm, ".en_at_start"}, 32'(trans_en), 32'd1);
        chk({nm, ".busy_at_start"}, 32'(busy), 32'd1);
        en_cycles = 1;
        lat = 0;
        got = 1'b0;
        for (int i = 1; i <= 100 && !got; i++) begin
            tick();
            // Sample g is taken from dut_out two edges earlier (synchronizer depth).
            if (g > 0 && i == S + g - 3) dut_out = gval;
            if (g > 0 && i == S + g - 2) dut_out = pat;
            if (valid) begin
                got = 1'b1;
                lat = i;
                chk({nm, ".en_off_at_valid"}, 32'(trans_en), 32'd0);
            end else if (trans_en) begin
                en_cycles++;
                chk({nm, ".dir"}, 32'(trans_dir), 32'd0);
            end
        end
        chk({nm, ".latency"}, 32'(lat), 32'(S + K));
        chk({nm, ".en_cycles"}, 32'(en_cycles), 32'(S + K));
        chk({nm, ".data"}, 32'(data), 32'(exp_d));
        chk({nm, ".unstable"}, 32'(unstable), 32'(exp_u));
    endtask

    task automatic release_hold(input string nm, input logic [15:0] exp_d, input logic exp_u);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk({nm, ".valid_drop"}, 32'(valid), 32'd0);
        chk({nm, ".busy_drop"}, 32'(busy), 32'd0);
        chk({nm, ".data_kept"}, 32'(data), 32'(exp_d));
        chk({nm, ".unstable_kept"}, 32'(unstable), 32'(exp_u));
    endtask

    initial begin
        bit seen_valid;

        vecs[0] = '{"basic",     16'hA5C3, 16'h0000, 0, 16'hA5C3, 1'b0};
        vecs[1] = '{"glitch_mid", 16'h1234, 16'h0000, 2, 16'h1234, 1'b1};
        vecs[2] = '{"glitch_last", 16'hFFFF, 16'h0000, 3, 16'h0000, 1'b1};
        vecs[3] = '{"glitch_first", 16'h0F0F, 16'hF0F0, 1, 16'h0F0F, 1'b1};
        vecs[4] = '{"clean_again", 16'h5555, 16'h0000, 0, 16'h5555, 1'b0};

        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        ready    = 1'b0;
        dut_out  = 16'hA5C3;
        exp_data = 16'h0000;
        mask     = 16'h0000;

        #12;
        chk("rst.trans_en", 32'(trans_en), 32'd0);
        chk("rst.trans_dir", 32'(trans_dir), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.valid", 32'(valid), 32'd0);
        chk("rst.unstable", 32'(unstable), 32'd0);
        chk("rst.data", 32'(data), 32'd0);
`ifdef VT_CAPTURE_COMPARE_EN
        chk("rst.mismatch", 32'(mismatch), 32'd0);
`endif
        rst_n = 1'b1;
        repeat (4) tick();

        foreach (vecs[v]) begin
            capture(vecs[v].name, vecs[v].pattern, vecs[v].glitch_val, vecs[v].glitch_idx,
                    vecs[v].exp_data, vecs[v].exp_unstable);
            release_hold(vecs[v].name, vecs[v].exp_data, vecs[v].exp_unstable);
            tick();
        end

        // Backpressure: hold for 20 cycles, with an ignored start pulse.
        capture("bp", 16'hA5C3, 16'h0000, 0, 16'hA5C3, 1'b0);
        for (int i = 0; i < 20; i++) begin
            start = (i == 5);
            tick();
            chk("bp.valid_held", 32'(valid), 32'd1);
            chk("bp.data_held", 32'(data), 32'hA5C3);
            chk("bp.en_low", 32'(trans_en), 32'd0);
            chk("bp.busy_high", 32'(busy), 32'd1);
        end
        // A start that coincides with ready must be dropped.
        start = 1'b1;
        ready = 1'b1;
        tick();
        start = 1'b0;
        ready = 1'b0;
        chk("bp.release_valid", 32'(valid), 32'd0);
        chk("bp.release_busy", 32'(busy), 32'd0);
        tick();
        chk("bp.start_dropped_busy", 32'(busy), 32'd0);
        chk("bp.start_dropped_en", 32'(trans_en), 32'd0);
        tick();

        // Abort on the third SETTLE cycle.
        dut_out = 16'h1111;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort.en", 32'(trans_en), 32'd0);
        chk("abort.busy", 32'(busy), 32'd0);
        seen_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (valid) seen_valid = 1'b1;
        end
        chk("abort.no_valid", 32'(seen_valid), 32'd0);
        chk("abort.data_kept", 32'(data), 32'hA5C3);
        chk("abort.busy_idle", 32'(busy), 32'd0);

        // Asynchronous reset while in SAMPLE, away from the clock edge.
        dut_out = 16'h2222;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        chk("arst.pre_en", 32'(trans_en), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst.en", 32'(trans_en), 32'd0);
        chk("arst.valid", 32'(valid), 32'd0);
        chk("arst.busy", 32'(busy), 32'd0);
        chk("arst.data", 32'(data), 32'd0);
        #1;
        rst_n = 1'b1;
        tick();
        tick();
        capture("arst_clean", 16'h2222, 16'h0000, 0, 16'h2222, 1'b0);
        release_hold("arst_clean", 16'h2222, 1'b0);
        tick();

`ifdef VT_CAPTURE_COMPARE_EN
        exp_data = 16'hA5C3;
        mask     = 16'hFF00;
        capture("cmp_hi", 16'hA5FF, 16'h0000, 0, 16'hA5FF, 1'b0);
        chk("cmp_hi.mismatch", 32'(mismatch), 32'd0);
        release_hold("cmp_hi", 16'hA5FF, 1'b0);
        tick();
        exp_data = 16'hA5C3;
        mask     = 16'h00FF;
        capture("cmp_lo", 16'hA5FF, 16'h0000, 0, 16'hA5FF, 1'b0);
        chk("cmp_lo.mismatch", 32'(mismatch), 32'd1);
        release_hold("cmp_lo", 16'hA5FF, 1'b0);
        chk("cmp_lo.mismatch_kept", 32'(mismatch), 32'd1);
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vt_response_capture.md
Name: vt_response_capture

Overview:
- Read-side counterpart of the ASIC tester's voltage-translator input path: the input-side controller enables translators to apply input vectors; this block enables the output-side translators and captures the DUT's response vector.
- On START it enables the translator in the B->A (DUT->tester) direction, waits a settle interval, and takes several consecutive synchronized samples of the DUT outputs.
- After sampling it disables the translator and presents the captured word with a VALID/READY handshake.
- The translator is enabled only during an active capture and is disabled at all other times.

Parameters:
- WIDTH, 16, width of the DUT output vector and the captured word.
- SETTLE_CYCLES, 8, number of cycles the translator is enabled before sampling starts. Legal range is 1..255.
- SAMPLES, 3, number of consecutive samples that must agree. Legal range is 1..15.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- START  input  1  single-cycle capture request. Sampled only in IDLE.
- ABORT  input  1  cancels a capture that is in progress.
- BUSY  output  1  high whenever state is not IDLE.
- DUT_OUT  input  WIDTH  DUT outputs from the translator A-side. Asynchronous to CLK.
- TRANS_EN  output  1  translator enable, active high.
- TRANS_DIR  output  1  translator direction. 0 = B->A (read).
- DATA  output  WIDTH  captured response word.
- VALID  output  1  DATA is available.
- READY  input  1  consumer accepts DATA.
- UNSTABLE  output  1  the samples disagreed during the capture that produced DATA.

Behaviour:
- Synchronizer:
  - DUT_OUT passes through a 2-flop synchronizer on every bit. The synchronizer runs continuously.
  - All samples are taken from the synchronizer output.
- Registered outputs: every output is registered. Reset values:
  - TRANS_EN=0, TRANS_DIR=0, BUSY=0, VALID=0, UNSTABLE=0.
  - DATA=0 and the synchronizer flops=0.
- Reset asserted mid-capture: RST_N low forces IDLE and all reset values immediately (asynchronously). TRANS_EN drops without waiting for a clock.
- FSM states: IDLE, SETTLE, SAMPLE, HOLD.
- IDLE:
  - START=1 at edge N -> SETTLE. From edge N onward TRANS_EN=1, BUSY=1, settle counter=0.
- SETTLE:
  - The counter increments each cycle.
  - When the counter reaches SETTLE_CYCLES-1 -> SAMPLE, and the sample counter is cleared.
- SAMPLE:
  - Each cycle captures one synchronized word. The first word is stored as the reference.
  - Any later word that differs from the reference sets a sticky mismatch bit.
  - After SAMPLES words -> HOLD. On that edge: DATA=last word, UNSTABLE=mismatch bit, VALID=1, TRANS_EN=0.
- Latency with START at edge N:
  - TRANS_EN is high for exactly SETTLE_CYCLES+SAMPLES cycles.
  - VALID rises at edge N+SETTLE_CYCLES+SAMPLES, on the same edge that TRANS_EN falls.
- HOLD:
  - VALID, DATA and UNSTABLE are held stable until READY=1.
  - On the edge where VALID&READY -> IDLE: VALID=0, BUSY=0. DATA and UNSTABLE keep their values.
- START:
  - START is ignored outside IDLE and is not queued.
  - START and READY arriving on the same cycle in HOLD: the START is dropped.
- ABORT:
  - ABORT=1 in SETTLE or SAMPLE -> IDLE on the next edge. TRANS_EN=0, no VALID, DATA unchanged.
  - ABORT has priority over the state-advance of that cycle.
  - ABORT in HOLD or IDLE has no effect.
- UNSTABLE is cleared only when a new capture sets it or on reset.
- SAMPLES=1: UNSTABLE is always 0.
- Counter widths are 8 bits for settle and 4 bits for sample. There is no wrap-around within the legal parameter ranges.

Optional Feature:
- Macro VT_CAPTURE_COMPARE_EN.
- When defined, the block adds:
  - EXP_DATA input WIDTH and MASK input WIDTH, both sampled on the START edge.
  - MISMATCH output 1, reset value 0.
- In HOLD, MISMATCH = |((DATA ^ EXP_DATA_latched) & MASK_latched). It is registered on the same edge as VALID and held with DATA.
- When undefined, those ports and their logic are absent. All other behaviour is identical.

Test Plan:
- Basic capture, with DUT_OUT=16'hA5C3 steady and START pulsed at edge 10:
  - TRANS_EN must be high on edges 10..20 (11 cycles), with TRANS_DIR=0.
  - VALID must rise at edge 21 with DATA=16'hA5C3 and UNSTABLE=0.
- Glitch: DUT_OUT toggles to 16'h0000 for one cycle during SAMPLE -> UNSTABLE=1, and VALID timing is unchanged.
- Backpressure: READY held low for 20 cycles -> VALID, DATA and TRANS_EN=0 stay stable. A START during the hold is ignored, so BUSY stays high. READY=1 -> IDLE on the next edge.
- Abort: ABORT at the 3rd SETTLE cycle -> TRANS_EN=0 and BUSY=0 on the next edge. VALID never rises and DATA keeps its previous value.
- Async reset: RST_N low for 2 ns mid-SAMPLE, off the clock edge -> TRANS_EN=0 and VALID=0 immediately. DATA=0. A subsequent START performs a clean capture.
- With VT_CAPTURE_COMPARE_EN defined: EXP_DATA=16'hA5C3, MASK=16'hFF00, DUT_OUT=16'hA5FF -> MISMATCH=0. With MASK=16'h00FF -> MISMATCH=1.
